// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches on a req/gnt/rvalid bus,
// buffers PC-tagged responses and presents the one matching pcF; flushes on redirect.
module ifetch_queue #(
    parameter int                   DEPTH      = 4,
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   INSTR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_SIZE-1:0]  pcF,
    input  logic                  advF,
    output logic [INSTR_SIZE-1:0] instrF,
    output logic                  validF,
    output logic                  fetch_stall,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INSTR_SIZE-1:0] imem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]            DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [INSTR_SIZE-1:0]  NOP     = INSTR_SIZE'(32'h0000_0013);
    localparam logic [ADDR_SIZE-1:0]   STEP    = ADDR_SIZE'(4);

    logic [ADDR_SIZE-1:0]  pc_mem    [DEPTH];
    logic [INSTR_SIZE-1:0] instr_mem [DEPTH];

    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outst;
    logic [CW-1:0]         drop;
    logic [ADDR_SIZE-1:0]  fpc;
    logic [ADDR_SIZE-1:0]  rpc;

    logic [ADDR_SIZE-1:0]  head_pc;
    logic [ADDR_SIZE-1:0]  epc;
    logic                  redirect;
    logic                  hit;
    logic                  room;
    logic                  grant;
    logic                  rsp;
    logic                  rsp_drop;
    logic                  push;
    logic                  pop;

    assign head_pc  = pc_mem[head];
    assign epc      = (count != '0) ? head_pc : rpc;
    assign redirect = (pcF != epc);
    assign hit      = (count != '0) && (head_pc == pcF);

    assign validF      = hit;
    assign fetch_stall = ~hit;
    assign instrF      = hit ? instr_mem[head] : NOP;

    // Requests are capped so that every outstanding response has a free slot.
    assign room      = ({1'b0, count} + {1'b0, outst}) < DEPTH_C;
    assign imem_req  = reset & ~redirect & room;
    assign imem_addr = fpc;

    assign grant    = imem_req & imem_gnt;
    assign rsp      = imem_rvalid & (outst != '0);
    assign rsp_drop = rsp & (drop != '0);
    assign push     = rsp & ~redirect & (drop == '0);
    assign pop      = hit & advF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            outst <= '0;
            drop  <= '0;
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
        end else if (redirect) begin
            // Everything still in flight belongs to the old path.
            head  <= '0;
            tail  <= '0;
            count <= '0;
            outst <= outst - CW'(rsp);
            drop  <= outst - CW'(rsp);
            fpc   <= pcF;
            rpc   <= pcF;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
                rpc  <= rpc + STEP;
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            if (grant) begin
                fpc <= fpc + STEP;
            end
            count <= count + CW'(push) - CW'(pop);
            outst <= outst + CW'(grant) - CW'(rsp);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= RESET_PC;
                instr_mem[i] <= NOP;
            end
        end else if (push) begin
            pc_mem[tail]    <= rpc;
            instr_mem[tail] <= imem_rdata;
        end
    end

endmodule
